seg_pattern_reader: RTL and testbench
=====================================

Name: seg_pattern_reader

Overview:
- Reads back a multiplexed, active-low seven-segment display bus (segment lines plus active-low digit anodes) and recovers the hex value shown on each digit.
- It is the inverse of the team's value-to-segment decoder. It is used for self-check and loop-back of the display path in the instruction-processor lab design.
- Each digit's pattern is qualified by a stability filter, then decoded. A one-cycle frame strobe fires once every digit has been captured.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; valid range 1..8.
- STABLE_CYCLES, 4, consecutive identical samples required before capture; valid range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  reader enable; when 0, no captures occur.
- seg_in  input  7  segment lines, active-low; bit 6 = a … bit 0 = g.
- an_in  input  NUM_DIGITS  digit selects, active-low; bit i low selects digit i.
- digits_out  output  4*NUM_DIGITS  decoded value; digit i is in bits [4i+3:4i].
- blank_out  output  NUM_DIGITS  1 = digit i last captured as blank (1111111).
- err_out  output  NUM_DIGITS  1 = digit i last captured as an illegal pattern.
- frame_valid  output  1  one-cycle pulse: every digit has been captured since the previous pulse.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - Reset values: digits_out = 0, blank_out = all 1, err_out = 0, frame_valid = 0.
  - Also at reset: internal sample registers = all 1, stability count = 0, capture mask = 0.
  - Reset asserted mid-scan discards partial captures and the mask.
- Input stage: seg_in and an_in are registered every edge. All further logic uses the registered copies.
- Qualification:
  - The registered {an, seg} is "valid" only when exactly one an bit is 0.
  - If valid and equal to the previous registered value, count <= min(count+1, STABLE_CYCLES).
  - If valid and different, count <= 1.
  - If not valid, count <= 0.
- Capture:
  - Occurs on the edge where count transitions to STABLE_CYCLES (for STABLE_CYCLES = 1, every valid new value).
  - Exactly one capture per stable interval; count saturates, so a held pattern never recaptures.
  - Latency: inputs constant before edge 1 → sampled at edges 1..STABLE_CYCLES → outputs change after edge STABLE_CYCLES+1 (edge 5 at default).
- Decode table (seg → value):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9
  - 0001000→A, 1100000→b, 0110001→C, 1000010→d, 0110000→E, 0111000→F
- Per-digit result on capture:
  - Table pattern: nibble = value, blank = 0, err = 0.
  - 1111111: nibble = 0, blank = 1, err = 0.
  - Any other pattern: nibble = 0, blank = 0, err = 1.
  - Only the selected digit's slot changes.
- Frame tracking:
  - Each capture sets mask[i].
  - Recapturing a digit already in the mask overwrites its slot; the mask is unchanged.
  - If a capture would make the mask all 1: mask <= 0 on that edge and frame_valid = 1 for the following cycle only.
- enable = 0:
  - count forced to 0 and mask cleared.
  - Slot outputs hold their values; frame_valid = 0.
  - Input registers keep sampling.
  - Re-enable requires a full STABLE_CYCLES interval before the next capture.
- No backpressure: frame_valid is a pulse, and slot outputs are always readable.

Test Plan:
- Reset then idle with seg_in = 1111111, an_in = 1111: digits_out = 0, blank_out = 1111, err_out = 0, frame_valid never pulses.
- Scan digits 0..3 (an 1110, 1101, 1011, 0111) showing 1, 2, 3, 4 (1001111, 0010010, 0000110, 1001100), each held 6 cycles, STABLE_CYCLES = 4 → digits_out = 16'h4321, blank_out = 0, err_out = 0. Exactly one frame_valid pulse, 1 cycle after digit 3's capture edge (edge 5 of its interval).
- Glitch filter: digit 0 shows 0000110 for 3 cycles, then 0100000 held 5 cycles → slot 0 = 6; the value 3 is never captured.
- Illegal and blank patterns: digit 2 shows 1010101, then a later frame shows 1111111 → err_out[2] = 1 then 0, and blank_out[2] = 1, nibble 0 in both cases.
- Invalid select: an_in = 1100 or 1111 for 10 cycles with a legal seg → no capture, mask unchanged, outputs unchanged.
- Mid-frame disruption: capture digits 0 and 1, then drop enable for 1 cycle (or pulse reset) → mask cleared. A subsequent full scan is required for frame_valid. After reset, outputs equal the reset values.

Source files
------------

// File: rtl/seg_pattern_reader.sv
// seg_pattern_reader
// Reads back a multiplexed, active-low seven-segment bus and recovers the
// hex value shown on each digit. Each digit pattern must be held for
// STABLE_CYCLES consecutive registered samples before it is captured. A
// one-cycle frame strobe fires once every digit has been captured.
`default_nettype none

module seg_pattern_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     an_in,
    output logic [4*NUM_DIGITS-1:0]   digits_out,
    output logic [NUM_DIGITS-1:0]     blank_out,
    output logic [NUM_DIGITS-1:0]     err_out,
    output logic                      frame_valid
);

    // Counter is wide enough for the largest allowed stability interval.
    localparam int              CW         = 8;
    localparam logic [CW-1:0]   STABLE_MAX = CW'(STABLE_CYCLES);
    localparam int              PW         = NUM_DIGITS + 7;

    // Registered copies of the display bus and the sample before them.
    logic [6:0]              seg_reg;
    logic [NUM_DIGITS-1:0]   an_reg;
    logic [PW-1:0]           prev_reg;

    // Stability qualification.
    logic [CW-1:0]           count_reg;
    logic [CW-1:0]           count_next;
    logic                    sel_valid;
    logic                    same_as_prev;
    logic                    capture;
    logic [NUM_DIGITS-1:0]   sel_onehot;

    // Frame tracking.
    logic [NUM_DIGITS-1:0]   mask_reg;
    logic [NUM_DIGITS-1:0]   mask_next;
    logic                    frame_reg;
    logic                    frame_next;

    // Decoded view of the currently registered segment pattern.
    logic [3:0]              dec_value;
    logic                    dec_blank;
    logic                    dec_err;

    // Register the raw bus every edge and keep the previous registered sample
    // so stability can be judged entirely on synchronised copies.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_reg  <= '1;
            an_reg   <= '1;
            prev_reg <= '1;
        end else begin
            prev_reg <= {an_reg, seg_reg};
            an_reg   <= an_in;
            seg_reg  <= seg_in;
        end
    end

    // A sample is usable only when exactly one digit anode is driven low.
    // x & (x-1) clears the lowest set bit, so it is zero only for one-hot x.
    assign sel_onehot   = ~an_reg;
    assign sel_valid    = (sel_onehot != '0) &&
                          ((sel_onehot & (sel_onehot - NUM_DIGITS'(1))) == '0);
    assign same_as_prev = ({an_reg, seg_reg} == prev_reg);

    // Next stability count and the capture decision. A capture happens only
    // on the edge where the count reaches STABLE_MAX; a saturated count on an
    // unchanged pattern never recaptures. With a one-sample interval every
    // new valid pattern lands straight on STABLE_MAX and is captured.
    always_comb begin
        count_next = '0;
        capture    = 1'b0;
        if (enable && sel_valid) begin
            if (same_as_prev) begin
                count_next = (count_reg >= STABLE_MAX) ? STABLE_MAX
                                                       : count_reg + CW'(1);
            end else begin
                count_next = CW'(1);
            end
            capture = (count_next == STABLE_MAX) &&
                      (!same_as_prev || (count_reg != STABLE_MAX));
        end
    end

    // Hold the stability count; disabling the reader restarts qualification.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Track which digits have been captured in the current frame and raise
    // the frame strobe on the capture that completes the set.
    always_comb begin
        mask_next  = mask_reg;
        frame_next = 1'b0;
        if (!enable) begin
            mask_next = '0;
        end else if (capture) begin
            if ((mask_reg | sel_onehot) == '1) begin
                mask_next  = '0;
                frame_next = 1'b1;
            end else begin
                mask_next = mask_reg | sel_onehot;
            end
        end
    end

    // Register the frame mask and the one-cycle frame strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_reg  <= '0;
            frame_reg <= 1'b0;
        end else begin
            mask_reg  <= mask_next;
            frame_reg <= frame_next;
        end
    end

    assign frame_valid = frame_reg;

    // Translate the active-low segment pattern (a..g = bit 6..0) to a nibble,
    // flagging the all-dark pattern as blank and anything unknown as illegal.
    always_comb begin
        dec_value = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg_reg)
            7'b0000001: dec_value = 4'h0;
            7'b1001111: dec_value = 4'h1;
            7'b0010010: dec_value = 4'h2;
            7'b0000110: dec_value = 4'h3;
            7'b1001100: dec_value = 4'h4;
            7'b0100100: dec_value = 4'h5;
            7'b0100000: dec_value = 4'h6;
            7'b0001111: dec_value = 4'h7;
            7'b0000000: dec_value = 4'h8;
            7'b0000100: dec_value = 4'h9;
            7'b0001000: dec_value = 4'hA;
            7'b1100000: dec_value = 4'hB;
            7'b0110001: dec_value = 4'hC;
            7'b1000010: dec_value = 4'hD;
            7'b0110000: dec_value = 4'hE;
            7'b0111000: dec_value = 4'hF;
            7'b1111111: dec_blank = 1'b1;
            default:    dec_err   = 1'b1;
        endcase
    end

    // One result slot per digit; only the slot of the selected digit changes.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            logic [3:0] nibble_reg;
            logic       blank_reg;
            logic       err_reg;

            // Overwrite this digit's slot when a capture targets it.
            always_ff @(posedge clk) begin
                if (reset) begin
                    nibble_reg <= 4'h0;
                    blank_reg  <= 1'b1;
                    err_reg    <= 1'b0;
                end else if (capture && sel_onehot[gi]) begin
                    nibble_reg <= dec_value;
                    blank_reg  <= dec_blank;
                    err_reg    <= dec_err;
                end
            end

            assign digits_out[4*gi +: 4] = nibble_reg;
            assign blank_out[gi]         = blank_reg;
            assign err_out[gi]           = err_reg;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_seg_pattern_reader.sv
// Testbench for seg_pattern_reader: drives multiplexed digit scans and checks
// captured slots directly and, through a scoreboard, at every frame strobe.
`timescale 1ns/1ps

module tb_seg_pattern_reader;

    localparam int ND = 4;
    localparam int SC = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [6:0]   seg_in;
    logic [ND-1:0] an_in;
    logic [4*ND-1:0] digits_out;
    logic [ND-1:0] blank_out;
    logic [ND-1:0] err_out;
    logic         frame_valid;

    int n_cmp    = 0;
    int n_bad    = 0;
    int n_frames = 0;
    int n_pushed = 0;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  b;
        logic [3:0]  e;
    } snap_t;

    snap_t sb_q[$];

    always #5 clk = ~clk;

    seg_pattern_reader #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digits_out  (digits_out),
        .blank_out   (blank_out),
        .err_out     (err_out),
        .frame_valid (frame_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Forward segment encoder (value -> active-low a..g).
    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'h0: enc = 7'b0000001;
            4'h1: enc = 7'b1001111;
            4'h2: enc = 7'b0010010;
            4'h3: enc = 7'b0000110;
            4'h4: enc = 7'b1001100;
            4'h5: enc = 7'b0100100;
            4'h6: enc = 7'b0100000;
            4'h7: enc = 7'b0001111;
            4'h8: enc = 7'b0000000;
            4'h9: enc = 7'b0000100;
            4'hA: enc = 7'b0001000;
            4'hB: enc = 7'b1100000;
            4'hC: enc = 7'b0110001;
            4'hD: enc = 7'b1000010;
            4'hE: enc = 7'b0110000;
            default: enc = 7'b0111000;
        endcase
    endfunction

    function automatic logic [3:0] sel(input int i);
        logic [3:0] s;
        s    = 4'b1111;
        s[i] = 1'b0;
        return s;
    endfunction

    task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic [15:0] d, input logic [3:0] b, input logic [3:0] e);
        sb_q.push_back({d, b, e});
        n_pushed++;
    endtask

    // Frame monitor: every strobe must match the oldest expected frame.
    always @(negedge clk) begin
        snap_t s;
        if (frame_valid === 1'b1) begin
            n_frames++;
            if (sb_q.size() == 0) begin
                check("frame_unexpected", 32'd1, 32'd0);
            end else begin
                s = sb_q.pop_front();
                check("frame_digits", 32'(digits_out), 32'(s.d));
                check("frame_blank", 32'(blank_out), 32'(s.b));
                check("frame_err", 32'(err_out), 32'(s.e));
            end
        end
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        seg_in = 7'h7F;
        an_in  = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_digits", 32'(digits_out), 32'h0);
        check("rst_blank", 32'(blank_out), 32'hF);
        check("rst_err", 32'(err_out), 32'h0);
        check("rst_fv", 32'(frame_valid), 32'h0);

        // Idle: blank pattern with no digit selected.
        show(4'hF, 7'h7F, 10);
        check("idle_digits", 32'(digits_out), 32'h0);
        check("idle_blank", 32'(blank_out), 32'hF);

        // Full scan 1,2,3,4 with frame-strobe timing on the last digit.
        for (int i = 0; i < 3; i++) show(sel(i), enc(4'(i + 1)), 6);
        expect_frame(16'h4321, 4'h0, 4'h0);
        an_in  = 4'b0111;
        seg_in = enc(4'h4);
        repeat (4) @(posedge clk);
        #1 check("fv_before", 32'(frame_valid), 32'h0);
        @(posedge clk);
        #1 check("fv_pulse", 32'(frame_valid), 32'h1);
        @(posedge clk);
        #1 check("fv_after", 32'(frame_valid), 32'h0);
        check("scan_digits", 32'(digits_out), 32'h4321);
        check("scan_blank", 32'(blank_out), 32'h0);

        // Glitch filter: 3 cycles of '3' must not capture; '6' held 5 does.
        show(4'b1110, enc(4'h3), 3);
        check("glitch_hold", 32'(digits_out[3:0]), 32'h1);
        show(4'b1110, enc(4'h6), 5);
        check("glitch_cap", 32'(digits_out[3:0]), 32'h6);
        show(4'hF, 7'h7F, 4);

        // Illegal pattern on digit 2, then complete the frame.
        show(4'b1011, 7'b1010101, 6);
        check("ill_err", 32'(err_out), 32'h4);
        check("ill_nib", 32'(digits_out[11:8]), 32'h0);
        show(4'b1101, enc(4'hA), 6);
        expect_frame(16'hF0A6, 4'h0, 4'h4);
        show(4'b0111, enc(4'hF), 6);

        // Blank on digit 2 in the next frame.
        show(4'b1110, enc(4'h8), 6);
        show(4'b1101, enc(4'hC), 6);
        show(4'b1011, 7'h7F, 6);
        expect_frame(16'hD0C8, 4'h4, 4'h0);
        show(4'b0111, enc(4'hD), 6);
        check("blank_err", 32'(err_out), 32'h0);
        check("blank_blank", 32'(blank_out), 32'h4);

        // Invalid selects leave slots and mask untouched.
        show(4'b1110, enc(4'h5), 6);
        show(4'b1100, enc(4'h1), 10);
        show(4'b1111, enc(4'h1), 10);
        check("inv_digits", 32'(digits_out), 32'hD0C5);
        check("inv_blank", 32'(blank_out), 32'h4);
        show(4'b1101, enc(4'h7), 6);
        show(4'b1011, enc(4'h9), 6);
        expect_frame(16'hB975, 4'h0, 4'h0);
        show(4'b0111, enc(4'hB), 6);

        // Disabled reader never captures; re-enable needs a full interval.
        enable = 1'b0;
        show(4'b1110, enc(4'h8), 10);
        check("dis_hold", 32'(digits_out[3:0]), 32'h5);
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("reen_early", 32'(digits_out[3:0]), 32'h5);
        @(posedge clk);
        #1 check("reen_cap", 32'(digits_out[3:0]), 32'h8);
        show(4'b1110, enc(4'h8), 2);

        // Enable drop mid-frame clears the mask; digits 2,3 alone give no frame.
        show(4'b1101, enc(4'h2), 6);
        show(4'hF, 7'h7F, 2);
        enable = 1'b0;
        @(posedge clk);
        #1 enable = 1'b1;
        show(4'hF, 7'h7F, 2);
        show(4'b1011, enc(4'h3), 6);
        show(4'b0111, enc(4'h4), 6);
        check("drop_digits", 32'(digits_out), 32'h4328);
        show(4'b1110, enc(4'h0), 6);
        expect_frame(16'h4310, 4'h0, 4'h0);
        show(4'b1101, enc(4'h1), 6);

        // Reset mid-frame: outputs return to reset values and mask clears.
        show(4'b1011, enc(4'h5), 6);
        show(4'b0111, enc(4'h6), 6);
        show(4'hF, 7'h7F, 2);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("mrst_digits", 32'(digits_out), 32'h0);
        check("mrst_blank", 32'(blank_out), 32'hF);
        check("mrst_err", 32'(err_out), 32'h0);
        check("mrst_fv", 32'(frame_valid), 32'h0);
        show(4'b1011, enc(4'h7), 6);
        show(4'b0111, enc(4'h8), 6);
        check("post_digits", 32'(digits_out), 32'h8700);
        check("post_blank", 32'(blank_out), 32'h3);
        show(4'b1110, enc(4'h9), 6);
        expect_frame(16'h87A9, 4'h0, 4'h0);
        show(4'b1101, enc(4'hA), 6);

        show(4'hF, 7'h7F, 5);
        check("sb_empty", 32'(sb_q.size()), 32'h0);
        check("frame_count", 32'(n_frames), 32'(n_pushed));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
